// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I decode stage.
// Holds:
//   - major opcode constants
//   - the canonical NOP encoding (ADDI x0, x0, 0)
//   - the decode FSM state type
//   - immediate-extraction helpers
// Each helper returns a 32-bit sign-extended immediate.
package rv32i_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHalt
    } id_state_e;

    function automatic logic [31:0] imm_i(input logic [31:0] iw);
        return {{20{iw[31]}}, iw[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] iw);
        return {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] iw);
        return {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv32i_id_stage_if.sv
// Fetch/EX-facing bus of the decode stage.
//
// Fetch side:
//   iw_in, pc_in, in_valid, in_ready   instruction handshake
//   jump_enable, jump_addr             redirect back to fetch
//
// EX side:
//   out_valid, out_ready               issue handshake
//   iw_out, pc_out, rs1/rs2_data_out   issued payload
//   wb_reg, wb_en_out                  writeback information
//
// Modports:
//   slave   the decode stage itself
//   master  its environment (fetch and EX)
interface rv32i_id_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic [31:0]     iw_in;
    logic [XLEN-1:0] pc_in;
    logic            in_valid;
    logic            in_ready;
    logic            jump_enable;
    logic [XLEN-1:0] jump_addr;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     iw_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] rs1_data_out;
    logic [XLEN-1:0] rs2_data_out;
    logic [4:0]      wb_reg;
    logic            wb_en_out;

    modport master (
        output iw_in, pc_in, in_valid, out_ready,
        input  in_ready, jump_enable, jump_addr, out_valid, iw_out, pc_out,
               rs1_data_out, rs2_data_out, wb_reg, wb_en_out
    );

    modport slave (
        input  iw_in, pc_in, in_valid, out_ready,
        output in_ready, jump_enable, jump_addr, out_valid, iw_out, pc_out,
               rs1_data_out, rs2_data_out, wb_reg, wb_en_out
    );
endinterface

// File: rtl/rv32i_fwd_mux.sv
// Operand select for one source register.
// Among enabled forwarding sources whose register matches rs, the lowest index wins.
// Otherwise the register-file value passes through. x0 always takes the register-file value.
//
// Ports:
//   rs         source register number
//   rf_data    register-file read data
//   df_enable  per-source valid
//   df_reg     per-source register, packed 5 bits each
//   df_data    per-source data, packed XLEN bits each
//   sel_data   selected operand
module rv32i_fwd_mux #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 3
) (
    input  logic [4:0]            rs,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [NUM_FWD-1:0]    df_enable,
    input  logic [5*NUM_FWD-1:0]  df_reg,
    input  logic [XLEN*NUM_FWD-1:0] df_data,
    output logic [XLEN-1:0]       sel_data
);

    always_comb begin
        sel_data = rf_data;
        if (rs != 5'd0) begin
            // Walk from the lowest priority up so the lowest index is written last.
            for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
                if (df_enable[i] && (df_reg[5*i +: 5] == rs)) begin
                    sel_data = df_data[XLEN*i +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/rv32i_id_stage.sv
// RV32I instruction decode stage.
// Functions:
//   - reads source registers and applies operand forwarding
//   - detects load-use hazards and inserts a bubble for them
//   - resolves jumps and branches
//   - squashes wrong-path instructions after a taken jump
//   - halts after a SYSTEM instruction
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   bus                   fetch/EX handshake and issued payload (slave side)
//   rs1_reg, rs2_reg      register-file read addresses
//   rs1_data_in, rs2_data_in  register-file read data
//   df_enable, df_reg, df_data  forwarding sources; index 0 has highest priority
//   ex_is_load, ex_rd     load currently in EX
//   halted                sticky halt indicator
module rv32i_id_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_FWD     = 3,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    rv32i_id_stage_if.slave         bus,
    output logic [4:0]              rs1_reg,
    output logic [4:0]              rs2_reg,
    input  logic [XLEN-1:0]         rs1_data_in,
    input  logic [XLEN-1:0]         rs2_data_in,
    input  logic [NUM_FWD-1:0]      df_enable,
    input  logic [5*NUM_FWD-1:0]    df_reg,
    input  logic [XLEN*NUM_FWD-1:0] df_data,
    input  logic                    ex_is_load,
    input  logic [4:0]              ex_rd,
    output logic                    halted
);

    localparam int unsigned CntW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH + 1) : 1;

    id_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            halted_q, halted_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     iw_q, iw_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [4:0]      wb_reg_q, wb_reg_d;
    logic            wb_en_q, wb_en_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            uses_rs1, uses_rs2, writes_rd;
    logic            hazard, xfer, taken, br_taken;
    logic [XLEN-1:0] target;

    assign opcode  = bus.iw_in[6:0];
    assign funct3  = bus.iw_in[14:12];
    assign rd      = bus.iw_in[11:7];
    assign rs1_reg = bus.iw_in[19:15];
    assign rs2_reg = bus.iw_in[24:20];

    rv32i_fwd_mux #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_rs1 (
        .rs        (rs1_reg),
        .rf_data   (rs1_data_in),
        .df_enable (df_enable),
        .df_reg    (df_reg),
        .df_data   (df_data),
        .sel_data  (rs1_fwd)
    );

    rv32i_fwd_mux #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_rs2 (
        .rs        (rs2_reg),
        .rf_data   (rs2_data_in),
        .df_enable (df_enable),
        .df_reg    (df_reg),
        .df_data   (df_data),
        .sel_data  (rs2_fwd)
    );

    // Opcode-dependent register usage.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OpLui, OpAuipc, OpJal: writes_rd = 1'b1;
            OpJalr, OpLoad, OpImm: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OpReg: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OpBranch, OpStore: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Squashed instructions in FLUSH never reach EX, so only RUN needs the interlock.
    assign hazard = (state_q == StRun) && ex_is_load && (ex_rd != 5'd0) &&
                    ((uses_rs1 && (ex_rd == rs1_reg)) || (uses_rs2 && (ex_rd == rs2_reg)));

    assign bus.in_ready = bus.out_ready && (state_q != StHalt) && !hazard;
    assign xfer         = bus.in_valid && bus.in_ready;

    always_comb begin
        unique case (funct3)
            3'b000:  br_taken = (rs1_fwd == rs2_fwd);
            3'b001:  br_taken = (rs1_fwd != rs2_fwd);
            3'b100:  br_taken = ($signed(rs1_fwd) <  $signed(rs2_fwd));
            3'b101:  br_taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            3'b110:  br_taken = (rs1_fwd <  rs2_fwd);
            3'b111:  br_taken = (rs1_fwd >= rs2_fwd);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = bus.pc_in;
        case (opcode)
            OpJal: begin
                taken  = 1'b1;
                target = bus.pc_in + XLEN'($signed(imm_j(bus.iw_in)));
            end
            OpJalr: begin
                taken  = 1'b1;
                target = (rs1_fwd + XLEN'($signed(imm_i(bus.iw_in)))) & ~XLEN'(1);
            end
            OpBranch: begin
                taken  = br_taken;
                target = bus.pc_in + XLEN'($signed(imm_b(bus.iw_in)));
            end
            default: ;
        endcase
    end

    assign bus.jump_enable = xfer && (state_q == StRun) && taken;
    assign bus.jump_addr   = bus.jump_enable ? target : bus.pc_in;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halted_d    = halted_q;
        out_valid_d = out_valid_q;
        iw_d        = iw_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        wb_reg_d    = wb_reg_q;
        wb_en_d     = wb_en_q;

        // With EX stalled, everything holds.
        if (bus.out_ready) begin
            // Idle issue slot: nothing valid goes to EX.
            out_valid_d = 1'b0;
            iw_d        = NopInstr;
            wb_reg_d    = 5'd0;
            wb_en_d     = 1'b0;

            unique case (state_q)
                StRun: begin
                    if (hazard && bus.in_valid) begin
                        out_valid_d = 1'b1;
                    end else if (xfer) begin
                        out_valid_d = 1'b1;
                        iw_d        = bus.iw_in;
                        pc_d        = bus.pc_in;
                        rs1_d       = rs1_fwd;
                        rs2_d       = rs2_fwd;
                        wb_reg_d    = rd;
                        wb_en_d     = writes_rd && (rd != 5'd0);
                        if (taken && (FLUSH_DEPTH > 0)) begin
                            state_d = StFlush;
                            cnt_d   = CntW'(FLUSH_DEPTH);
                        end else if (opcode == OpSystem) begin
                            state_d  = StHalt;
                            halted_d = 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (xfer) begin
                        out_valid_d = 1'b1;
                        pc_d        = bus.pc_in;
                        if (cnt_q <= CntW'(1)) begin
                            state_d = StRun;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end
                StHalt: out_valid_d = 1'b1;
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            iw_q        <= NopInstr;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            wb_reg_q    <= 5'd0;
            wb_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
            out_valid_q <= out_valid_d;
            iw_q        <= iw_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            wb_reg_q    <= wb_reg_d;
            wb_en_q     <= wb_en_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.iw_out       = iw_q;
    assign bus.pc_out       = pc_q;
    assign bus.rs1_data_out = rs1_q;
    assign bus.rs2_data_out = rs2_q;
    assign bus.wb_reg       = wb_reg_q;
    assign bus.wb_en_out    = wb_en_q;
    assign halted           = halted_q;

endmodule

// File: tb/tb_rv32i_id_stage.sv
// Directed bench for rv32i_id_stage.
// Inputs change 1 time unit after the rising edge.
// Combinational outputs are checked 1 unit after that.
// Registered outputs are checked 1 unit after the next rising edge.
module tb_rv32i_id_stage;
    import rv32i_pkg::*;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned NUM_FWD     = 3;
    localparam int unsigned FLUSH_DEPTH = 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [4:0]              rs1_reg, rs2_reg;
    logic [XLEN-1:0]         rs1_data_in, rs2_data_in;
    logic [NUM_FWD-1:0]      df_enable;
    logic [5*NUM_FWD-1:0]    df_reg;
    logic [XLEN*NUM_FWD-1:0] df_data;
    logic                    ex_is_load;
    logic [4:0]              ex_rd;
    logic                    halted;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] add_655, add_431, beq_i, jalr_i, jal_i, ebreak_i, addi_i;

    always #5 clk = ~clk;

    rv32i_id_stage_if #(.XLEN(XLEN)) bus ();

    rv32i_id_stage #(
        .XLEN        (XLEN),
        .NUM_FWD     (NUM_FWD),
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .rs1_reg     (rs1_reg),
        .rs2_reg     (rs2_reg),
        .rs1_data_in (rs1_data_in),
        .rs2_data_in (rs2_data_in),
        .df_enable   (df_enable),
        .df_reg      (df_reg),
        .df_data     (df_data),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic drive(input logic [31:0] iw, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.iw_in    = iw;
        bus.pc_in    = pc;
        bus.in_valid = 1'b1;
        rs1_data_in  = r1;
        rs2_data_in  = r2;
        #1;
    endtask

    initial begin
        add_655  = enc_r(5'd6, 5'd5, 5'd5);
        add_431  = enc_r(5'd4, 5'd3, 5'd1);
        beq_i    = enc_b(13'h1FF8, 5'd1, 5'd2, 3'b000);
        jalr_i   = enc_i(12'd4, 5'd1, 3'b000, 5'd1, 7'b1100111);
        jal_i    = enc_j(21'd16, 5'd1);
        ebreak_i = enc_i(12'd1, 5'd0, 3'b000, 5'd0, 7'b1110011);
        addi_i   = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011);

        reset         = 1'b0;
        bus.iw_in     = 32'h0;
        bus.pc_in     = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rs1_data_in   = '0;
        rs2_data_in   = '0;
        df_enable     = '0;
        df_reg        = '0;
        df_data       = '0;
        ex_is_load    = 1'b0;
        ex_rd         = 5'd0;

        // Asynchronous reset values, before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_iw_out", bus.iw_out, 32'h13);
        check("rst_pc_out", bus.pc_out, 0);
        check("rst_rs1_data", bus.rs1_data_out, 0);
        check("rst_wb_en", bus.wb_en_out, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_halted", halted, 0);
        tick();
        reset = 1'b0;
        tick();

        // Forwarding: RF x5=1, df[0]=x5/7, df[2]=x5/9 -> 7 on both operands.
        df_enable = 3'b101;
        df_reg    = {5'd5, 5'd0, 5'd5};
        df_data   = {32'd9, 32'd0, 32'd7};
        drive(add_655, 32'h40, 32'd1, 32'd1);
        check("fwd_rs1_reg", rs1_reg, 5);
        check("fwd_rs2_reg", rs2_reg, 5);
        check("fwd_in_ready", bus.in_ready, 1);
        check("fwd_jump_en", bus.jump_enable, 0);
        check("fwd_jump_addr", bus.jump_addr, 32'h40);
        tick();
        check("fwd_rs1_data", bus.rs1_data_out, 7);
        check("fwd_rs2_data", bus.rs2_data_out, 7);
        check("fwd_iw_out", bus.iw_out, add_655);
        check("fwd_pc_out", bus.pc_out, 32'h40);
        check("fwd_wb_reg", bus.wb_reg, 6);
        check("fwd_wb_en", bus.wb_en_out, 1);
        check("fwd_out_valid", bus.out_valid, 1);

        // Only df[2] enabled -> 9.
        df_enable = 3'b100;
        drive(add_655, 32'h44, 32'd1, 32'd1);
        tick();
        check("fwd2_rs1_data", bus.rs1_data_out, 9);

        // x0 is never forwarded, even with every source matching x0.
        df_enable = 3'b111;
        df_reg    = '0;
        df_data   = {32'd3, 32'd2, 32'd1};
        drive(enc_r(5'd6, 5'd0, 5'd0), 32'h48, 32'h11, 32'h22);
        tick();
        check("x0_rs1_data", bus.rs1_data_out, 32'h11);
        check("x0_rs2_data", bus.rs2_data_out, 32'h22);
        df_enable = '0;

        // Load-use on x3: one bubble, then the ADD issues.
        ex_is_load = 1'b1;
        ex_rd      = 5'd3;
        drive(add_431, 32'h50, 32'h30, 32'h10);
        check("lu_in_ready", bus.in_ready, 0);
        tick();
        check("lu_bubble_iw", bus.iw_out, 32'h13);
        check("lu_bubble_wb_en", bus.wb_en_out, 0);
        check("lu_bubble_valid", bus.out_valid, 1);
        ex_is_load = 1'b0;
        #1;
        check("lu_in_ready2", bus.in_ready, 1);
        tick();
        check("lu_iw_out", bus.iw_out, add_431);
        check("lu_wb_reg", bus.wb_reg, 4);
        check("lu_rs1_data", bus.rs1_data_out, 32'h30);

        // BNE with equal operands: not taken, jump_addr = pc_in.
        drive(enc_b(13'h1FF8, 5'd1, 5'd2, 3'b001), 32'h60, 32'd5, 32'd5);
        check("bne_jump_en", bus.jump_enable, 0);
        check("bne_jump_addr", bus.jump_addr, 32'h60);
        tick();
        // BLTU -1 < 1 unsigned: not taken.
        drive(enc_b(13'h1FF8, 5'd1, 5'd2, 3'b110), 32'h64, 32'hFFFF_FFFF, 32'd1);
        check("bltu_jump_en", bus.jump_enable, 0);
        tick();
        // Undefined funct3 010: not taken.
        drive(enc_b(13'h1FF8, 5'd1, 5'd2, 3'b010), 32'h68, 32'd5, 32'd5);
        check("f3_010_jump_en", bus.jump_enable, 0);
        tick();

        // BEQ taken at 0x100, imm -8 -> 0xF8; next instruction squashed.
        drive(beq_i, 32'h100, 32'd5, 32'd5);
        check("beq_jump_en", bus.jump_enable, 1);
        check("beq_jump_addr", bus.jump_addr, 32'hF8);
        tick();
        check("beq_iw_out", bus.iw_out, beq_i);
        check("beq_wb_en", bus.wb_en_out, 0);
        drive(add_655, 32'hF8, 32'd1, 32'd1);
        check("flush_jump_en", bus.jump_enable, 0);
        check("flush_in_ready", bus.in_ready, 1);
        tick();
        check("flush_iw_out", bus.iw_out, 32'h13);
        check("flush_wb_en", bus.wb_en_out, 0);
        check("flush_valid", bus.out_valid, 1);
        drive(add_655, 32'hFC, 32'd1, 32'd1);
        tick();
        check("post_flush_iw", bus.iw_out, add_655);

        // BLT -1 < 1 signed: taken, pc 0x80 -8 -> 0x78.
        drive(enc_b(13'h1FF8, 5'd1, 5'd2, 3'b100), 32'h80, 32'hFFFF_FFFF, 32'd1);
        check("blt_jump_en", bus.jump_enable, 1);
        check("blt_jump_addr", bus.jump_addr, 32'h78);
        tick();
        drive(add_655, 32'h78, 32'd1, 32'd1);
        tick();
        check("blt_squash_iw", bus.iw_out, 32'h13);

        // JALR behind a load-use on x1: stall wins, no jump until accepted.
        ex_is_load = 1'b1;
        ex_rd      = 5'd1;
        drive(jalr_i, 32'h300, 32'h203, 32'd0);
        check("jalr_stall_ready", bus.in_ready, 0);
        check("jalr_stall_jump", bus.jump_enable, 0);
        check("jalr_stall_addr", bus.jump_addr, 32'h300);
        tick();
        check("jalr_stall_iw", bus.iw_out, 32'h13);
        ex_is_load = 1'b0;
        #1;
        check("jalr_jump_en", bus.jump_enable, 1);
        check("jalr_jump_addr", bus.jump_addr, 32'h206);
        tick();
        check("jalr_iw_out", bus.iw_out, jalr_i);
        check("jalr_wb_en", bus.wb_en_out, 1);
        check("jalr_wb_reg", bus.wb_reg, 1);

        // EX stalls for 3 cycles during FLUSH: outputs hold, in_ready low.
        bus.out_ready = 1'b0;
        drive(add_655, 32'h206, 32'd1, 32'd1);
        for (int c = 0; c < 3; c++) begin
            check("hold_in_ready", bus.in_ready, 0);
            tick();
            check("hold_iw_out", bus.iw_out, jalr_i);
            check("hold_pc_out", bus.pc_out, 32'h300);
        end
        bus.out_ready = 1'b1;
        #1;
        tick();
        check("hold_squash_iw", bus.iw_out, 32'h13);
        drive(add_655, 32'h20A, 32'd1, 32'd1);
        tick();
        check("hold_next_iw", bus.iw_out, add_655);
        check("hold_next_pc", bus.pc_out, 32'h20A);

        // Reset mid-FLUSH: first post-reset instruction is not squashed.
        drive(jal_i, 32'h500, 32'd0, 32'd0);
        check("jal_jump_addr", bus.jump_addr, 32'h510);
        tick();
        check("jal_wb_en", bus.wb_en_out, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(add_655, 32'h510, 32'd1, 32'd1);
        tick();
        check("rst_flush_iw", bus.iw_out, add_655);

        // EBREAK then ADDI: halt, NOPs, then reset out of HALT.
        drive(ebreak_i, 32'h400, 32'd0, 32'd0);
        tick();
        check("ebreak_iw_out", bus.iw_out, ebreak_i);
        check("ebreak_halted", halted, 1);
        check("ebreak_wb_en", bus.wb_en_out, 0);
        drive(addi_i, 32'h404, 32'd0, 32'd0);
        check("halt_in_ready", bus.in_ready, 0);
        tick();
        check("halt_iw_out", bus.iw_out, 32'h13);
        check("halt_valid", bus.out_valid, 1);
        tick();
        check("halt_sticky", halted, 1);
        reset = 1'b1;
        #1;
        check("halt_rst_halted", halted, 0);
        check("halt_rst_iw", bus.iw_out, 32'h13);
        check("halt_rst_pc", bus.pc_out, 0);
        check("halt_rst_valid", bus.out_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        check("post_halt_ready", bus.in_ready, 1);
        tick();
        check("post_halt_iw", bus.iw_out, addi_i);
        check("post_halt_wb_en", bus.wb_en_out, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
